// File: rtl/clkbranch_pkg.sv
// -----------------------------------------------------------------------------
// clkbranch_pkg
// Shared definitions for the clock-branch enable sequencer and its helpers.
//   state_e    : sequencer state (idle / settling after an enable change)
//   idx_width  : width of a branch index for a given branch count
//   N_MIN..    : legal parameter ranges, checked at elaboration by the top
// -----------------------------------------------------------------------------
package clkbranch_pkg;

  localparam int N_MIN      = 2;
  localparam int N_MAX      = 16;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // A single-branch design still needs a one-bit index to stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkbranch_seq_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-one finder. Searches mask starting at bit
// ptr, then ptr+1, ... wrapping modulo N, and reports the first set bit.
// Ports:
//   mask  [N-1:0]  candidate bits
//   ptr   [IW-1:0] search start position (must be < N)
//   idx   [IW-1:0] index of the first set bit found
//   valid          high when any mask bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import clkbranch_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int cand;

  // Walk from the farthest position back to ptr so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (mask[cand]) begin
        idx   = IW'(cand);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkbranch_seq.sv
// -----------------------------------------------------------------------------
// clkbranch_seq
// Sequences per-branch clock-gate enables so that only one branch changes at a
// time, each change followed by a SETTLE-cycle quiet window.
// Ports:
//   CLK       free-running sequencer clock
//   RST       synchronous, active-high reset
//   REQ [N]   level request per branch (1 = clock wanted on)
//   EN  [N]   registered clock-gate enable per branch
//   ACK [N]   registered; follows EN[i] once branch i has settled
//   BUSY      high while a change is settling
//   VDD/VSS   power pins, no function
// -----------------------------------------------------------------------------
module clkbranch_seq
  import clkbranch_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 3,
  parameter int CNTW   = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] EN,
  output logic [N-1:0] ACK,
  output logic         BUSY,
  inout  wire          VDD,
  inout  wire          VSS
);

  localparam int IW = idx_width(N);

  // Reject illegal configurations at elaboration time.
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("clkbranch_seq: N out of range");
  end
  if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("clkbranch_seq: SETTLE out of range");
  end
  if ((1 << CNTW) <= SETTLE) begin : g_bad_cntw
    $error("clkbranch_seq: CNTW too narrow for SETTLE");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    en_q, en_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    pending;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  // Power pins carry no logic; folded into a sink so they count as used.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  // A branch is pending whenever its request disagrees with its enable.
  assign pending = REQ ^ en_q;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .mask  (pending),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state logic: grant one toggle from IDLE, then count out the settle
  // window before publishing the new enable on ACK.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          en_d[pick_idx] = ~en_q[pick_idx];
          idx_d          = pick_idx;
          ptr_d          = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
          cnt_d          = CNTW'(SETTLE - 1);
          state_d        = ST_SETTLE;
          busy_d         = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          ack_d[idx_q] = en_q[idx_q];
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state lives here; reset abandons any change in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign EN   = en_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_clkbranch_seq.sv
// -----------------------------------------------------------------------------
// tb_clkbranch_seq
// Drives three sequencer instances (N=4/SETTLE=3, N=16/SETTLE=1,
// N=4/SETTLE=15). Stimulus pushes hand-computed output events (cycle plus
// EN/ACK/BUSY snapshot) into per-instance queues; a monitor pops one entry
// every time an instance's outputs change and compares.
// -----------------------------------------------------------------------------
module tb_clkbranch_seq;

  typedef struct packed {
    int          cyc;
    logic [15:0] en;
    logic [15:0] ack;
    logic        busy;
  } exp_t;

  logic        CLK;
  logic        rst;
  logic [3:0]  req_a;
  logic [15:0] req_b;
  logic [3:0]  req_c;
  logic [3:0]  en_a, ack_a;
  logic [15:0] en_b, ack_b;
  logic [3:0]  en_c, ack_c;
  logic        busy_a, busy_b, busy_c;
  wire         vdd;
  wire         vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  exp_t        exp_q[3][$];
  logic [15:0] obs_en[3], obs_ack[3];
  logic        obs_busy[3];
  logic [15:0] prev_en[3], prev_ack[3];
  logic        prev_busy[3];

  clkbranch_seq #(.N(4), .SETTLE(3), .CNTW(4)) dut_a (
    .CLK(CLK), .RST(rst), .REQ(req_a), .EN(en_a), .ACK(ack_a),
    .BUSY(busy_a), .VDD(vdd), .VSS(vss)
  );

  clkbranch_seq #(.N(16), .SETTLE(1), .CNTW(4)) dut_b (
    .CLK(CLK), .RST(rst), .REQ(req_b), .EN(en_b), .ACK(ack_b),
    .BUSY(busy_b), .VDD(vdd), .VSS(vss)
  );

  clkbranch_seq #(.N(4), .SETTLE(15), .CNTW(4)) dut_c (
    .CLK(CLK), .RST(rst), .REQ(req_c), .EN(en_c), .ACK(ack_c),
    .BUSY(busy_c), .VDD(vdd), .VSS(vss)
  );

  assign obs_en[0]   = {12'b0, en_a};
  assign obs_ack[0]  = {12'b0, ack_a};
  assign obs_busy[0] = busy_a;
  assign obs_en[1]   = en_b;
  assign obs_ack[1]  = ack_b;
  assign obs_busy[1] = busy_b;
  assign obs_en[2]   = {12'b0, en_c};
  assign obs_ack[2]  = {12'b0, ack_c};
  assign obs_busy[2] = busy_c;

  // Free-running clock and an edge counter used to time-stamp events.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to posedge+1 of cycle c; all stimulus changes happen there.
  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input int d, input logic [15:0] r);
    case (d)
      0:       req_a = r[3:0];
      1:       req_b = r;
      default: req_c = r[3:0];
    endcase
  endtask

  task automatic expectEvent(input int d, input int c, input logic [15:0] en,
                             input logic [15:0] ack, input logic busy);
    exp_t e;
    e.cyc  = c;
    e.en   = en;
    e.ack  = ack;
    e.busy = busy;
    exp_q[d].push_back(e);
  endtask

  // Reset pulse covering exactly one edge; requests of dut_a drop with it.
  task automatic resetPulse();
    rst   = 1'b1;
    req_a = '0;
    stepTo(cyc + 1);
    rst   = 1'b0;
  endtask

  // Monitor: every output change of an instance consumes one expected event.
  exp_t mon_e;
  always @(negedge CLK) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (obs_en[d] !== prev_en[d] || obs_ack[d] !== prev_ack[d] ||
            obs_busy[d] !== prev_busy[d]) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut%0d_unexpected cyc=%0d en=%h ack=%h busy=%b",
                     d, cyc, obs_en[d], obs_ack[d], obs_busy[d]);
          end else begin
            mon_e = exp_q[d].pop_front();
            checkOutput($sformatf("dut%0d_event_cycle", d),
                        64'(cyc), 64'(mon_e.cyc));
            checkOutput($sformatf("dut%0d_event_value@%0d", d, mon_e.cyc),
                        64'({obs_busy[d], obs_ack[d], obs_en[d]}),
                        64'({mon_e.busy, mon_e.ack, mon_e.en}));
          end
          prev_en[d]   = obs_en[d];
          prev_ack[d]  = obs_ack[d];
          prev_busy[d] = obs_busy[d];
        end
      end
    end
  end

  int t, t1, t2, t3;

  initial begin
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    repeat (3) @(posedge CLK);
    #1;
    rst = 1'b0;

    checkOutput("reset_a", 64'({busy_a, ack_a, en_a}), 64'(0));
    checkOutput("reset_b", 64'({busy_b, ack_b, en_b}), 64'(0));
    checkOutput("reset_c", 64'({busy_c, ack_c, en_c}), 64'(0));
    for (int d = 0; d < 3; d++) begin
      prev_en[d]   = '0;
      prev_ack[d]  = '0;
      prev_busy[d] = 1'b0;
    end
    mon_en = 1'b1;

    // Single request: EN at +1, BUSY for three cycles, ACK at +4.
    t = cyc;
    applyStimulus(0, 16'h0001);
    expectEvent(0, t + 1, 16'h0001, 16'h0000, 1'b1);
    expectEvent(0, t + 4, 16'h0001, 16'h0001, 1'b0);
    stepTo(t + 6);

    // Simultaneous requests from ptr=0: bits 0,1,3 served, bit 2 untouched.
    t = cyc;
    expectEvent(0, t + 1, 16'h0000, 16'h0000, 1'b0);
    resetPulse();
    t = cyc;
    applyStimulus(0, 16'h000B);
    expectEvent(0, t + 1,  16'h0001, 16'h0000, 1'b1);
    expectEvent(0, t + 4,  16'h0001, 16'h0001, 1'b0);
    expectEvent(0, t + 5,  16'h0003, 16'h0001, 1'b1);
    expectEvent(0, t + 8,  16'h0003, 16'h0003, 1'b0);
    expectEvent(0, t + 9,  16'h000B, 16'h0003, 1'b1);
    expectEvent(0, t + 12, 16'h000B, 16'h000B, 1'b0);
    stepTo(t + 14);

    // Fairness: move ptr to 2 by toggling branch 1 twice, then contend.
    t = cyc;
    expectEvent(0, t + 1, 16'h0000, 16'h0000, 1'b0);
    resetPulse();
    t = cyc;
    applyStimulus(0, 16'h0002);
    expectEvent(0, t + 1, 16'h0002, 16'h0000, 1'b1);
    expectEvent(0, t + 4, 16'h0002, 16'h0002, 1'b0);
    stepTo(t + 6);
    t1 = cyc;
    applyStimulus(0, 16'h0000);
    expectEvent(0, t1 + 1, 16'h0000, 16'h0002, 1'b1);
    expectEvent(0, t1 + 4, 16'h0000, 16'h0000, 1'b0);
    stepTo(t1 + 6);
    t2 = cyc;
    applyStimulus(0, 16'h0003);
    expectEvent(0, t2 + 1, 16'h0001, 16'h0000, 1'b1);
    expectEvent(0, t2 + 4, 16'h0001, 16'h0001, 1'b0);
    expectEvent(0, t2 + 5, 16'h0003, 16'h0001, 1'b1);
    expectEvent(0, t2 + 8, 16'h0003, 16'h0003, 1'b0);
    stepTo(t2 + 10);
    // ptr is now 2: of pending bits 0 and 2, bit 2 must go first.
    t3 = cyc;
    applyStimulus(0, 16'h0006);
    expectEvent(0, t3 + 1, 16'h0007, 16'h0003, 1'b1);
    expectEvent(0, t3 + 4, 16'h0007, 16'h0007, 1'b0);
    expectEvent(0, t3 + 5, 16'h0006, 16'h0007, 1'b1);
    expectEvent(0, t3 + 8, 16'h0006, 16'h0006, 1'b0);
    stepTo(t3 + 10);

    // Withdrawal mid-settle: change completes, then is reversed.
    t = cyc;
    expectEvent(0, t + 1, 16'h0000, 16'h0000, 1'b0);
    resetPulse();
    t = cyc;
    applyStimulus(0, 16'h0001);
    expectEvent(0, t + 1, 16'h0001, 16'h0000, 1'b1);
    expectEvent(0, t + 4, 16'h0001, 16'h0001, 1'b0);
    expectEvent(0, t + 5, 16'h0000, 16'h0001, 1'b1);
    expectEvent(0, t + 8, 16'h0000, 16'h0000, 1'b0);
    stepTo(t + 2);
    applyStimulus(0, 16'h0000);
    stepTo(t + 10);

    // Short pulse on branch 1, gone before IDLE, is ignored.
    t = cyc;
    applyStimulus(0, 16'h0001);
    expectEvent(0, t + 1, 16'h0001, 16'h0000, 1'b1);
    expectEvent(0, t + 4, 16'h0001, 16'h0001, 1'b0);
    stepTo(t + 1);
    applyStimulus(0, 16'h0003);
    stepTo(t + 2);
    applyStimulus(0, 16'h0001);
    stepTo(t + 7);

    // Reset during branch 2 settle (ptr=3); afterwards search restarts at 0.
    t = cyc;
    expectEvent(0, t + 1, 16'h0000, 16'h0000, 1'b0);
    resetPulse();
    t = cyc;
    applyStimulus(0, 16'h000F);
    expectEvent(0, t + 1,  16'h0001, 16'h0000, 1'b1);
    expectEvent(0, t + 4,  16'h0001, 16'h0001, 1'b0);
    expectEvent(0, t + 5,  16'h0003, 16'h0001, 1'b1);
    expectEvent(0, t + 8,  16'h0003, 16'h0003, 1'b0);
    expectEvent(0, t + 9,  16'h0007, 16'h0003, 1'b1);
    expectEvent(0, t + 11, 16'h0000, 16'h0000, 1'b0);
    stepTo(t + 10);
    rst = 1'b1;
    applyStimulus(0, 16'h000A);
    stepTo(t + 11);
    rst = 1'b0;
    t1 = cyc;
    expectEvent(0, t1 + 1, 16'h0002, 16'h0000, 1'b1);
    expectEvent(0, t1 + 4, 16'h0002, 16'h0002, 1'b0);
    expectEvent(0, t1 + 5, 16'h000A, 16'h0002, 1'b1);
    expectEvent(0, t1 + 8, 16'h000A, 16'h000A, 1'b0);
    stepTo(t1 + 10);

    // N=16, SETTLE=1: changes two cycles apart, search wraps 15 -> 0.
    t = cyc;
    applyStimulus(1, 16'h4000);
    expectEvent(1, t + 1, 16'h4000, 16'h0000, 1'b1);
    expectEvent(1, t + 2, 16'h4000, 16'h4000, 1'b0);
    stepTo(t + 3);
    t1 = cyc;
    applyStimulus(1, 16'hC001);
    expectEvent(1, t1 + 1, 16'hC000, 16'h4000, 1'b1);
    expectEvent(1, t1 + 2, 16'hC000, 16'hC000, 1'b0);
    expectEvent(1, t1 + 3, 16'hC001, 16'hC000, 1'b1);
    expectEvent(1, t1 + 4, 16'hC001, 16'hC001, 1'b0);
    stepTo(t1 + 6);

    // SETTLE=15 in a 4-bit counter: full window both directions.
    t = cyc;
    applyStimulus(2, 16'h0004);
    expectEvent(2, t + 1,  16'h0004, 16'h0000, 1'b1);
    expectEvent(2, t + 16, 16'h0004, 16'h0004, 1'b0);
    stepTo(t + 17);
    t1 = cyc;
    applyStimulus(2, 16'h0000);
    expectEvent(2, t1 + 1,  16'h0000, 16'h0004, 1'b1);
    expectEvent(2, t1 + 16, 16'h0000, 16'h0000, 1'b0);
    stepTo(t1 + 18);

    // Any expected event never observed is a failed comparison.
    for (int d = 0; d < 3; d++) begin
      while (exp_q[d].size() > 0) begin
        exp_t e;
        e = exp_q[d].pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL dut%0d_missing_event actual=none required=cyc%0d en=%h ack=%h busy=%b",
                 d, e.cyc, e.en, e.ack, e.busy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
